vote_session_ctrl: RTL and testbench

Session sequencer for the 5-voter ballot. Collects one vote per voter during a timed voting window, tallies, and drives the vote count `x` and majority result `res` into the two-bank seven-segment display block for a fixed show period. Sits between the voter pushbuttons/start key and the display module; the display stays purely combinational.

---
 rtl/vote_session_ctrl.sv | 160 ++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Five-voter ballot session sequencer: timed voting window, tally, held display of count/result.
// Define VOTE_SESSION_CTRL_SYNC_EN to insert a 2-FF synchronizer ahead of the edge detectors.
module vote_session_ctrl #(
  parameter int VOTE_WINDOW = 1000,
  parameter int SHOW_TIME   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] vote_btn,
  output logic [2:0] x,
  output logic       res,
  output logic       res_valid,
  output logic       busy,
  output logic [4:0] vote_mask
);

  localparam int TMAX = (VOTE_WINDOW > SHOW_TIME) ? VOTE_WINDOW : SHOW_TIME;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTING = 2'd1,
    S_TALLY  = 2'd2,
    S_SHOW   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    mask_q, mask_d;
  logic [2:0]    x_q, x_d;
  logic          res_q, res_d;

  // Bit 5 is start, bits 4:0 are the voter buttons.
  logic [5:0] raw_in, in_s, edge_q, evt;
  logic       start_evt;
  logic [4:0] vote_evt;
  logic [2:0] mask_cnt;

  assign raw_in = {start, vote_btn};

`ifdef VOTE_SESSION_CTRL_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = raw_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= '0;
    else        edge_q <= in_s;
  end

  assign evt       = in_s & ~edge_q;
  assign start_evt = evt[5];
  assign vote_evt  = evt[4:0];

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) cnt = cnt + 3'(v[i]);
    return cnt;
  endfunction

  assign mask_cnt = popcount5(mask_q);

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    x_d     = x_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        x_d    = 3'd0;
        res_d  = 1'b0;
        mask_d = 5'd0;
        if (start_evt) begin
          timer_d = TW'(VOTE_WINDOW - 1);
          state_d = S_VOTING;
        end
      end

      S_VOTING: begin
        // A vote landing on the exit cycle still makes it into the mask.
        mask_d = mask_q | vote_evt;
        x_d    = mask_cnt;
        res_d  = 1'b0;
        if (timer_q == '0 || mask_q == 5'b11111) begin
          state_d = S_TALLY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_TALLY: begin
        x_d     = mask_cnt;
        res_d   = (mask_cnt >= 3'd3);
        timer_d = TW'(SHOW_TIME - 1);
        state_d = S_SHOW;
      end

      S_SHOW: begin
        if (start_evt) begin
          x_d     = 3'd0;
          res_d   = 1'b0;
          mask_d  = 5'd0;
          timer_d = TW'(VOTE_WINDOW - 1);
          state_d = S_VOTING;
        end else if (timer_q == '0) begin
          x_d     = 3'd0;
          res_d   = 1'b0;
          mask_d  = 5'd0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      mask_q  <= '0;
      x_q     <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      x_q     <= x_d;
      res_q   <= res_d;
    end
  end

  assign x         = x_q;
  assign res       = res_q;
  assign vote_mask = mask_q;
  assign res_valid = (state_q == S_SHOW);
  assign busy      = (state_q == S_VOTING) || (state_q == S_TALLY);

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: a table of {inputs, cycles, expected outputs} rows plus
// hand-written reset sequences. Uses a short window/show time to keep sessions compact.
module tb_vote_session_ctrl;

  localparam int VW = 20;
  localparam int ST = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] vote_btn;
  logic [2:0] x;
  logic       res;
  logic       res_valid;
  logic       busy;
  logic [4:0] vote_mask;

  int tests_run;
  int tests_failed;

  vote_session_ctrl #(
    .VOTE_WINDOW(VW),
    .SHOW_TIME  (ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vote_btn (vote_btn),
    .x        (x),
    .res      (res),
    .res_valid(res_valid),
    .busy     (busy),
    .vote_mask(vote_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [4:0] vb;
    int         n;
    logic [2:0] x;
    logic [4:0] m;
    logic       r;
    logic       rv;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic [4:0] vb, input int n, input logic [2:0] ex,
                     input logic [4:0] em, input logic er, input logic erv, input logic eb);
    vec_t v;
    v.start = s;  v.vb = vb; v.n = n;
    v.x = ex; v.m = em; v.r = er; v.rv = erv; v.b = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ex, input logic [4:0] em,
                           input logic er, input logic erv, input logic eb);
    check({tag, ".x"},         8'(x),         8'(ex));
    check({tag, ".vote_mask"}, 8'(vote_mask), 8'(em));
    check({tag, ".res"},       8'(res),       8'(er));
    check({tag, ".res_valid"}, 8'(res_valid), 8'(erv));
    check({tag, ".busy"},      8'(busy),      8'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    vote_btn = 5'd0;

    // Session 1: majority pass, voter 2 twice, start during VOTING ignored.
    add(1, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);
    add(0, 5'h01,  1, 3'd0, 5'h01, 0, 0, 1);
    add(0, 5'h00,  1, 3'd1, 5'h01, 0, 0, 1);
    add(0, 5'h04,  1, 3'd1, 5'h05, 0, 0, 1);
    add(0, 5'h00,  1, 3'd2, 5'h05, 0, 0, 1);
    add(0, 5'h04,  1, 3'd2, 5'h05, 0, 0, 1);
    add(0, 5'h00,  1, 3'd2, 5'h05, 0, 0, 1);
    add(0, 5'h10,  1, 3'd2, 5'h15, 0, 0, 1);
    add(1, 5'h00,  1, 3'd3, 5'h15, 0, 0, 1);
    add(0, 5'h00, 11, 3'd3, 5'h15, 0, 0, 1);
    add(0, 5'h00,  1, 3'd3, 5'h15, 0, 0, 1);
    add(0, 5'h00,  1, 3'd3, 5'h15, 1, 1, 0);
    add(0, 5'h00,  7, 3'd3, 5'h15, 1, 1, 0);
    add(0, 5'h00,  1, 3'd0, 5'h00, 0, 0, 0);
    // Session 2: simultaneous votes by 1 and 3, majority fails, then start aborts SHOW.
    add(1, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);
    add(0, 5'h0A,  1, 3'd0, 5'h0A, 0, 0, 1);
    add(0, 5'h00,  1, 3'd2, 5'h0A, 0, 0, 1);
    add(0, 5'h00, 17, 3'd2, 5'h0A, 0, 0, 1);
    add(0, 5'h00,  1, 3'd2, 5'h0A, 0, 0, 1);
    add(0, 5'h00,  1, 3'd2, 5'h0A, 0, 1, 0);
    add(1, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);
    add(0, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);
    // Session 3: all five vote, early close into TALLY, show runs out to IDLE.
    add(0, 5'h03,  1, 3'd0, 5'h03, 0, 0, 1);
    add(0, 5'h1F,  1, 3'd2, 5'h1F, 0, 0, 1);
    add(0, 5'h1F,  1, 3'd5, 5'h1F, 0, 0, 1);
    add(0, 5'h00,  1, 3'd5, 5'h1F, 1, 1, 0);
    add(0, 5'h00,  7, 3'd5, 5'h1F, 1, 1, 0);
    add(0, 5'h00,  1, 3'd0, 5'h00, 0, 0, 0);
    add(0, 5'h1F,  2, 3'd0, 5'h00, 0, 0, 0);
    // Session 4: single vote arriving on the timeout cycle is still counted.
    add(1, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);
    add(0, 5'h00, 19, 3'd0, 5'h00, 0, 0, 1);
    add(0, 5'h08,  1, 3'd0, 5'h08, 0, 0, 1);
    add(0, 5'h00,  1, 3'd1, 5'h08, 0, 1, 0);
    add(1, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);
    add(0, 5'h00,  1, 3'd0, 5'h00, 0, 0, 1);

    #12;
    check_all("reset", 3'd0, 5'h00, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (x !== 3'd0 || vote_mask !== 5'd0 || res !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0)
        bad = 1'b1;
    end
    check("idle50", 8'(bad), 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start    = vecs[i].start;
      vote_btn = vecs[i].vb;
      repeat (vecs[i].n) tick();
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].m, vecs[i].r, vecs[i].rv, vecs[i].b);
    end

    // Async reset in VOTING with two votes in; outputs must clear before any clock edge.
    vote_btn = 5'h05;
    tick();
    vote_btn = 5'h00;
    tick();
    check("pre_reset.x", 8'(x), 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 3'd0, 5'h00, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_all("post_reset_idle", 3'd0, 5'h00, 0, 0, 0);

    start = 1'b1;
    tick();
    check_all("restart", 3'd0, 5'h00, 0, 0, 1);
    start    = 1'b0;
    vote_btn = 5'h01;
    tick();
    vote_btn = 5'h00;
    tick();
    check_all("restart_vote", 3'd1, 5'h01, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
